// File: rtl/serial_det_pkg.sv
// Shared types, defaults and the pattern comparison helper for the serial pattern detector.
package serial_det_pkg;

  typedef enum logic {FILL, RUN} det_state_t;

  localparam int unsigned DEFAULT_PAT_LEN = 4;
  localparam logic [15:0] DEFAULT_PATTERN = 16'b1011;

  // Compares only the low len bits; callers zero-extend narrower values.
  function automatic logic pattern_hit(logic [15:0] value, logic [15:0] pattern,
                                       int unsigned len);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < len && value[i] != pattern[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Serial bit stream input plus match/status outputs of the pattern detector.
interface serial_pattern_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clear;
  logic             bit_in;
  logic             bit_valid;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             filled;

  modport master (
    output clear, bit_in, bit_valid,
    input  match, match_count, filled
  );

  modport slave (
    input  clear, bit_in, bit_valid,
    output match, match_count, filled
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && count_q != '1) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/serial_pattern_detector.sv
// Detects a fixed PAT_LEN-bit pattern (overlapping) in a qualified serial stream;
// pulses match one cycle after the completing bit and keeps a saturating hit count.
module serial_pattern_detector
  import serial_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN[PAT_LEN-1:0],
  parameter int unsigned        CNT_W   = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  serial_pattern_detector_if.slave bus
);
  localparam int unsigned FW = $clog2(PAT_LEN + 1);

  det_state_t         state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic               match_q;
  logic               hit;
  logic [CNT_W-1:0]   count;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    shreg_d = bus.bit_valid ? {shreg_q[PAT_LEN-2:0], bus.bit_in} : shreg_q;
    // The completing bit may be the one that finishes the fill.
    hit = bus.bit_valid && pattern_hit(16'(shreg_d), 16'(PATTERN), PAT_LEN) &&
          (state_q == RUN || fill_q == FW'(PAT_LEN - 1));
    if (bus.bit_valid && state_q == FILL) begin
      fill_d = fill_q + FW'(1);
      if (fill_q == FW'(PAT_LEN - 1)) state_d = RUN;
    end
    if (bus.clear) begin
      state_d = FILL;
      fill_d  = '0;
      shreg_d = '0;
      hit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      shreg_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      shreg_q <= shreg_d;
      match_q <= hit;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (bus.clear),
    .inc    (hit),
    .count  (count)
  );

  assign bus.match       = match_q;
  assign bus.match_count = count;
  assign bus.filled      = (state_q == RUN);
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: a default instance plus a CNT_W=2 instance
// fed the same stream to observe saturation.
module tb_serial_pattern_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_pattern_detector_if #(.CNT_W(8)) mif ();
  serial_pattern_detector_if #(.CNT_W(2)) sif ();

  assign sif.clear     = mif.clear;
  assign sif.bit_in    = mif.bit_in;
  assign sif.bit_valid = mif.bit_valid;

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (mif.slave)
  );

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (sif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, returns 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    mif.bit_valid = v;
    mif.bit_in    = v ? b : 1'bx;
    mif.clear     = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] s1;
    logic [3:0] hist;
    logic [7:0] lfsr;
    int         nbits;
    int         refcnt;
    logic       b;
    logic       e;

    mif.bit_valid = 1'b0;
    mif.bit_in    = 1'b0;
    mif.clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(mif.match), 32'd0);
    chk("rst_count", 32'(mif.match_count), 32'd0);
    chk("rst_filled", 32'(mif.filled), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 1011011 -> hits after bits 4 and 7
    s1 = 7'b1011011;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s1[i], 1'b0);
      chk($sformatf("t1_match_b%0d", 7 - i), 32'(mif.match), 32'((i == 3) || (i == 0)));
      chk($sformatf("t1_filled_b%0d", 7 - i), 32'(mif.filled), 32'(i <= 3));
    end
    chk("t1_count", 32'(mif.match_count), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_match_idle", 32'(mif.match), 32'd0);

    step(1'b0, 1'b0, 1'b1);
    chk("clr_count", 32'(mif.match_count), 32'd0);
    chk("clr_filled", 32'(mif.filled), 32'd0);

    // 2: 011, five idle cycles, 011 -> single hit on the final bit
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_fill_nomatch", 32'(mif.match), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("t2_gap%0d", i), 32'(mif.match), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("t2_m4", 32'(mif.match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_m5", 32'(mif.match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_m6", 32'(mif.match), 32'd1);
    chk("t2_count", 32'(mif.match_count), 32'd1);

    // 3: 1011 x5 -> the 2-bit counter sticks at 3
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("t3_pre%0d", k), 32'(sif.match), 32'd0);
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("t3_match%0d", k), 32'(sif.match), 32'd1);
      chk($sformatf("t3_satcnt%0d", k), 32'(sif.match_count), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("t3_cnt%0d", k), 32'(mif.match_count), 32'(k));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("t3_sat_hold", 32'(sif.match_count), 32'd3);

    // 4: async reset mid-stream, after ...1,0,1 with a hit already counted
    step(1'b0, 1'b0, 1'b1);
    s1 = 7'b0101101;
    for (int i = 5; i >= 0; i--) step(1'b1, s1[i], 1'b0);
    chk("t4_pre_count", 32'(mif.match_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_count", 32'(mif.match_count), 32'd0);
    chk("t4_async_filled", 32'(mif.filled), 32'd0);
    chk("t4_async_match", 32'(mif.match), 32'd0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("t4_no_stale", 32'(mif.match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_pre_hit", 32'(mif.match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_fresh_hit", 32'(mif.match), 32'd1);
    chk("t4_count", 32'(mif.match_count), 32'd1);

    // 5: clear coincident with a completing bit drops it
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_match", 32'(mif.match), 32'd0);
    chk("t5_count", 32'(mif.match_count), 32'd0);
    chk("t5_filled", 32'(mif.filled), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_after", 32'(mif.match), 32'd0);

    // 6: pseudo-random stream against a windowed reference count
    step(1'b0, 1'b0, 1'b1);
    lfsr   = 8'hA5;
    hist   = 4'b0000;
    nbits  = 0;
    refcnt = 0;
    for (int i = 0; i < 100; i++) begin
      b    = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      step(1'b1, b, 1'b0);
      hist  = {hist[2:0], b};
      nbits++;
      e = (nbits >= 4) && (hist == 4'b1011);
      if (e) refcnt++;
      chk($sformatf("t6_match%0d", i), 32'(mif.match), 32'(e));
    end
    chk("t6_count", 32'(mif.match_count), 32'(refcnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
